muldiv_seq: RTL and testbench

//  Iterative RV64M multiply/divide sequencer beside the core's combinational ALU.

---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_muldiv_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared funct3 codes, FSM states and signedness helpers for the RV64M multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int XLEN_DEF = 64;
  localparam int WLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift-add multiply / restoring-divide datapath.
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub_val;
  logic            fits;

  // The shifted remainder needs one extra bit so unsigned divisors above 2^(XLEN-1) compare correctly.
  always_comb begin
    add_sum = {1'b0, acc} + {1'b0, (lo[0] ? opb : {XLEN{1'b0}})};
    shifted = {acc, lo[XLEN-1]};
    fits    = shifted >= {1'b0, opb};
    sub_val = shifted[XLEN-1:0] - opb;
    if (div_mode) begin
      acc_nxt = fits ? sub_val : shifted[XLEN-1:0];
      lo_nxt  = {lo[XLEN-2:0], fits};
    end else begin
      acc_nxt = add_sum[XLEN:1];
      lo_nxt  = {add_sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer; *W ops are built only when MULDIV_WORD_OPS_EN is defined,
// otherwise an is_word request completes immediately with res=0.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int WLEN = WLEN_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_WORD = CW'(WLEN - 1);

  state_t          state, state_nxt;
  logic [2:0]      op_q;
  logic            word_q, neg_main_q, neg_rem_q;
  logic [XLEN-1:0] acc_q, lo_q, opb_q, res_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_nxt, lo_nxt;

  logic            div_op, word_op, illegal_op, sgn_a, sgn_b, b_zero, ovf, special;
  logic [XLEN-1:0] opa, opb, mag_full_a, mag_full_b, mag_a, mag_b, special_res;
  logic [XLEN-1:0] prod_lo, prod_hi, rem_val, fix_val, fix_res;

  // Word ops run on sign-extended low halves; magnitudes are trimmed back to WLEN bits for the loop.
  always_comb begin
    div_op = funct3[2];
`ifdef MULDIV_WORD_OPS_EN
    word_op    = is_word;
    illegal_op = 1'b0;
`else
    word_op    = 1'b0;
    illegal_op = is_word;
`endif
    opa        = word_op ? {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]} : a;
    opb        = word_op ? {{(XLEN-WLEN){b[WLEN-1]}}, b[WLEN-1:0]} : b;
    sgn_a      = a_is_signed(funct3) & opa[XLEN-1];
    sgn_b      = b_is_signed(funct3) & opb[XLEN-1];
    mag_full_a = sgn_a ? -opa : opa;
    mag_full_b = sgn_b ? -opb : opb;
    mag_a      = word_op ? {{(XLEN-WLEN){1'b0}}, mag_full_a[WLEN-1:0]} : mag_full_a;
    mag_b      = word_op ? {{(XLEN-WLEN){1'b0}}, mag_full_b[WLEN-1:0]} : mag_full_b;
    b_zero     = word_op ? (b[WLEN-1:0] == '0) : (b == '0);
    ovf        = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (word_op ? ((a[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}}) && (&b[WLEN-1:0]))
                          : ((a == {1'b1, {(XLEN-1){1'b0}}}) && (&b)));
    special    = illegal_op || (div_op && (b_zero || ovf));
    special_res = '0;
    if (!illegal_op && b_zero) special_res = funct3[1] ? opa : '1;
    else if (!illegal_op && ovf) special_res = funct3[1] ? '0 : opa;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode (op_q[2]),
    .acc      (acc_q),
    .lo       (lo_q),
    .opb      (opb_q),
    .acc_nxt  (acc_nxt),
    .lo_nxt   (lo_nxt)
  );

  // The {acc,lo} pair is negated as one 2*XLEN value so MULH* high halves get the borrow from the low half.
  always_comb begin
    prod_lo = neg_main_q ? -lo_q : lo_q;
    prod_hi = neg_main_q ? (~acc_q + XLEN'(lo_q == '0)) : acc_q;
    rem_val = neg_rem_q ? -acc_q : acc_q;
    fix_val = prod_lo;
    case (op_q)
      F3_MUL:                       fix_val = word_q ? (prod_lo >> (XLEN-WLEN)) : prod_lo;
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_hi;
      F3_DIV, F3_DIVU:              fix_val = prod_lo;
      default:                      fix_val = rem_val;
    endcase
    fix_res = word_q ? {{(XLEN-WLEN){fix_val[WLEN-1]}}, fix_val[WLEN-1:0]} : fix_val;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !flush) state_nxt = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (flush)            state_nxt = ST_IDLE;
        else if (cnt_q == '0) state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q       <= '0;
      word_q     <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      acc_q      <= '0;
      lo_q       <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op_q       <= funct3;
            word_q     <= word_op;
            neg_main_q <= sgn_a ^ sgn_b;
            neg_rem_q  <= sgn_a;
            acc_q      <= '0;
            lo_q       <= (div_op && word_op) ? (mag_a << (XLEN-WLEN)) : mag_a;
            opb_q      <= mag_b;
            cnt_q      <= word_op ? CNT_WORD : CNT_FULL;
            if (special) res_q <= special_res;
          end
        end
        ST_CALC: begin
          if (!flush) begin
            acc_q <= acc_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_FIX: begin
          if (!flush) res_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_CALC) || (state == ST_FIX);
  assign done = (state == ST_DONE);
  assign res  = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: randomized and directed M-extension ops checked against plain-arithmetic reference.
module tb_muldiv_seq;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  funct3;
  logic        is_word;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] res;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] res;
    int          done_cyc;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  muldiv_seq dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .funct3  (funct3),
    .is_word (is_word),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .res     (res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference results straight from the RISC-V M rules using wide native arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic w,
                                          input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] xs, ys;
    logic [127:0]        p;
    logic signed [63:0]  x64, y64, q64;
    logic signed [31:0]  x32, y32, q32;
    logic [31:0]         ux32, uy32;
    x64 = x; y64 = y; xs = x64; ys = y64;
    x32 = x[31:0]; y32 = y[31:0]; ux32 = x[31:0]; uy32 = y[31:0];
    if (w) begin
`ifdef MULDIV_WORD_OPS_EN
      case (f3)
        3'b000: return sext32(ux32 * uy32);
        3'b100: begin
          if (uy32 == 0) return '1;
          if (ux32 == 32'h8000_0000 && uy32 == 32'hFFFF_FFFF) return sext32(32'h8000_0000);
          q32 = x32 / y32;
          return sext32(q32);
        end
        3'b101: return (uy32 == 0) ? '1 : sext32(ux32 / uy32);
        3'b110: begin
          if (uy32 == 0) return sext32(ux32);
          if (ux32 == 32'h8000_0000 && uy32 == 32'hFFFF_FFFF) return '0;
          q32 = x32 % y32;
          return sext32(q32);
        end
        3'b111: return (uy32 == 0) ? sext32(ux32) : sext32(ux32 % uy32);
        default: return '0;
      endcase
`else
      return '0;
`endif
    end
    case (f3)
      3'b000: return x * y;
      3'b001: begin p = xs * ys; return p[127:64]; end
      3'b010: begin p = xs * {64'b0, y}; return p[127:64]; end
      3'b011: begin p = {64'b0, x} * {64'b0, y}; return p[127:64]; end
      3'b100: begin
        if (y == 0) return '1;
        if (x == MIN64 && y == '1) return MIN64;
        q64 = x64 / y64;
        return q64;
      end
      3'b101: return (y == 0) ? '1 : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (x == MIN64 && y == '1) return '0;
        q64 = x64 % y64;
        return q64;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] x, input logic [63:0] y);
    logic signed_div;
    signed_div = (f3 == 3'b100) || (f3 == 3'b110);
    if (w) begin
`ifdef MULDIV_WORD_OPS_EN
      if (f3[2] && (y[31:0] == 0 ||
          (signed_div && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF))) return 1;
      return 34;
`else
      return 1;
`endif
    end
    if (f3[2] && (y == 0 || (signed_div && x == MIN64 && y == '1))) return 1;
    return 66;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 64'd1;
      2:       return '1;
      3:       return MIN64;
      4:       return {32'h0, $urandom};
      5:       return {32'hFFFF_FFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one op, queue its expected result/done cycle, then wait (bounded) for the monitor to retire it.
  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic w,
                               input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    int   waited;
    @(negedge clk);
    start = 1'b1; funct3 = f3; is_word = w; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res      = ref_res(f3, w, x, y);
    e.done_cyc = cyc + ref_lat(f3, w, x, y) - 1;
    e.name     = name;
    sb_q.push_back(e);
    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout got=no_done expected=done within 200 cycles", name);
      sb_q.delete();
    end
  endtask

  // Monitor: retires scoreboard entries on done and checks busy while an op is in flight.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb_q.pop_front();
          checkOutput({e.name, "_res"}, res, e.res);
          checkOutput({e.name, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
          checkOutput({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
        end
      end else if (sb_q.size() != 0) begin
        checkOutput({sb_q[0].name, "_busy"}, 64'(busy), 64'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=no_finish expected=finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [2:0] f3;
    logic       w;
    rstn = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; is_word = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_res", res, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    applyStimulus("mul_7_m3", 3'b000, 1'b0, 64'd7, -64'sd3);
    applyStimulus("mulhu_max", 3'b011, 1'b0, '1, '1);
    applyStimulus("mulhsu_m1_2", 3'b010, 1'b0, '1, 64'd2);
    applyStimulus("mulh_neg", 3'b001, 1'b0, MIN64, 64'd3);
    applyStimulus("div_m7_2", 3'b100, 1'b0, -64'sd7, 64'd2);
    applyStimulus("rem_m7_2", 3'b110, 1'b0, -64'sd7, 64'd2);
    applyStimulus("divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7);
    applyStimulus("remu_100_7", 3'b111, 1'b0, 64'd100, 64'd7);

    // Async reset mid-CALC must clear outputs without waiting for a clock edge.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; is_word = 1'b0; a = 64'd12345; b = 64'd678;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("midcalc_reset_busy", 64'(busy), 64'd0);
    checkOutput("midcalc_reset_done", 64'(done), 64'd0);
    checkOutput("midcalc_reset_res", res, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    applyStimulus("div_by_zero", 3'b100, 1'b0, 64'd42, 64'd0);
    applyStimulus("rem_5_by_zero", 3'b110, 1'b0, 64'd5, 64'd0);
    applyStimulus("div_min_m1", 3'b100, 1'b0, MIN64, '1);
    applyStimulus("rem_min_m1", 3'b110, 1'b0, MIN64, '1);
    applyStimulus("divu_big", 3'b101, 1'b0, '1, 64'h8000_0000_0000_0001);
    applyStimulus("divw_ovf", 3'b100, 1'b1, 64'h0000_0001_8000_0000, '1);
    applyStimulus("mulw_wrap", 3'b000, 1'b1, 64'h1_0000, 64'h1_0000);
    applyStimulus("remw_neg", 3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);
    applyStimulus("divuw_big", 3'b101, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1);

    // Flush during cycle 20 of a divide: op aborted, busy drops in cycle 21, no done.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; is_word = 1'b0; a = 64'd1000; b = 64'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy_after", 64'(busy), 64'd0);
    checkOutput("flush_no_done", 64'(done), 64'd0);
    repeat (80) @(negedge clk);

    // start together with flush in IDLE is dropped, even for a zero-latency divide-by-zero.
    start = 1'b1; flush = 1'b1; funct3 = 3'b100; is_word = 1'b0; a = 64'd9; b = 64'd0;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    checkOutput("start_flush_busy", 64'(busy), 64'd0);
    checkOutput("start_flush_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 3) == 0);
      if (w && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011)) f3 = 3'b000;
      applyStimulus($sformatf("rand%0d_f%0d_w%0d", i, f3, w), f3, w, pick_operand(), pick_operand());
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
